meas_capture_ctrl: RTL and testbench

Parametrised multi-channel ADC capture controller. It replaces the fixed 2-channel test-pattern FIFO path.
- Captures a programmable number of points after a command-interface START.
- Optionally averages 2^k samples per point, and buffers results in an internal synchronous FIFO.
- Drains the FIFO through a read strobe from the SPI readout logic.
- Sits between the ADC front end (already synchronised to sys_clk as a sample strobe) and the SPI slave register decoder.

---
 rtl/meas_capture_ctrl_pkg.sv | 27 ++
 rtl/meas_capture_ctrl_if.sv | 33 +++
 rtl/meas_capture_ctrl_fifo.sv | 89 ++++++++
 rtl/meas_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_meas_capture_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/meas_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture controller: register map, CTRL bits,
// FSM state encoding and STATUS field layout.
package meas_pkg;

  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_CTRL    = 7'h01;
  localparam logic [6:0] ADDR_NPOINTS = 7'h02;
  localparam logic [6:0] ADDR_AVG     = 7'h03;
  localparam logic [6:0] ADDR_STATUS  = 7'h04;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_ABORT_BIT   = 1;
  localparam int CTRL_CLR_ERR_BIT = 2;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_ERR_BIT   = 2;
  localparam int STAT_EMPTY_BIT = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } meas_state_e;

endpackage

// File: rtl/meas_capture_ctrl_if.sv
// Bundle of command bus, ADC sample stream and FIFO readout port of the
// capture controller; master = register/readout side, slave = controller.
interface meas_capture_ctrl_if #(
  parameter int ADC_WIDTH = 12,
  parameter int CHANNELS  = 2
);
  localparam int DW = ADC_WIDTH * CHANNELS;

  logic          cmd_valid;
  logic          cmd_wr;
  logic [6:0]    cmd_addr;
  logic [23:0]   cmd_wdata;
  logic [23:0]   cmd_rdata;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          meas_done;
  logic          err;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, adc_valid, adc_data, rd_en,
    input  cmd_rdata, rd_data, rd_valid, busy, meas_done, err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, adc_valid, adc_data, rd_en,
    output cmd_rdata, rd_data, rd_valid, busy, meas_done, err
  );

endinterface

// File: rtl/meas_capture_ctrl_fifo.sv
// Single-clock FIFO with wrap-bit pointers, synchronous flush and registered
// dout/empty/full/count. dout holds its value between pops.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             do_push_s, do_pop_s;

  // Pointer/flag next-state; flush overrides push and pop
  always_comb begin
    do_push_s = push & ~full_q & ~flush;
    do_pop_s  = pop & ~empty_q & ~flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dout_d    = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        dout_d   = mem[rd_ptr_q[AW-1:0]];
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Storage array, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Pointer, flag and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/meas_capture_ctrl.sv
// Multi-channel ADC capture controller: register interface, capture FSM,
// per-channel 2^k averaging and a point FIFO drained by the readout logic.
module meas_capture_ctrl
  import meas_pkg::*;
#(
  parameter int          ADC_WIDTH    = 12,
  parameter int          CHANNELS     = 2,
  parameter int          DEPTH        = 4096,
  parameter int          AVG_LOG2_MAX = 4,
  parameter logic [23:0] DEVICE_ID    = 24'hF0CCAB
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  meas_capture_ctrl_if.slave   bus
);

  localparam int DW    = ADC_WIDTH * CHANNELS;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2_MAX;
  localparam int AVW   = $clog2(AVG_LOG2_MAX + 1);
  localparam int CW    = AVG_LOG2_MAX + 1;

  meas_state_e      state_q, state_d;
  logic [PW-1:0]    npoints_q, npoints_d;
  logic [AVW-1:0]   avg_q, avg_d;
  logic [PW-1:0]    pts_q, pts_d;
  logic [CW-1:0]    smp_cnt_q, smp_cnt_d;
  logic             push_pend_q, push_pend_d;
  logic [ACC_W-1:0] acc_q [CHANNELS];
  logic [ACC_W-1:0] acc_d [CHANNELS];
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [23:0]      cmd_rdata_q, cmd_rdata_d;

  logic             wr_s, rd_s, ctrl_wr_s;
  logic             start_s, abort_s, clr_err_s;
  logic             in_capture_s, flush_s, push_s, pop_s, rd_req_s;
  logic             err_set_s;
  logic [CW-1:0]    group_len_s;
  logic [CW-1:0]    smp_next_s;
  logic [PW-1:0]    pts_next_s;
  logic [DW-1:0]    push_word_s;
  logic [23:0]      status_s;

  logic [DW-1:0]    fifo_dout_s;
  logic             fifo_empty_s, fifo_full_s;
  logic [PW-1:0]    fifo_count_s;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (push_word_s),
    .pop   (pop_s),
    .flush (flush_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  // Command decode, FSM/accumulator next state and register readback
  always_comb begin
    wr_s         = bus.cmd_valid & bus.cmd_wr;
    rd_s         = bus.cmd_valid & ~bus.cmd_wr;
    ctrl_wr_s    = wr_s && (bus.cmd_addr == ADDR_CTRL);
    start_s      = ctrl_wr_s & bus.cmd_wdata[CTRL_START_BIT];
    abort_s      = ctrl_wr_s & bus.cmd_wdata[CTRL_ABORT_BIT];
    clr_err_s    = ctrl_wr_s & bus.cmd_wdata[CTRL_CLR_ERR_BIT];
    in_capture_s = (state_q == ST_CAPTURE);
    flush_s      = abort_s | (start_s & ~in_capture_s);
    push_s       = in_capture_s & push_pend_q & ~abort_s & ~fifo_full_s;
    rd_req_s     = bus.rd_en & ~in_capture_s & ~flush_s;
    pop_s        = rd_req_s & ~fifo_empty_s;
    group_len_s  = CW'(1) << avg_q;
    smp_next_s   = smp_cnt_q + CW'(1);
    pts_next_s   = pts_q + PW'(1);
    for (int c = 0; c < CHANNELS; c++) begin
      push_word_s[c*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(acc_q[c] >> avg_q);
    end

    state_d     = state_q;
    npoints_d   = npoints_q;
    avg_d       = avg_q;
    pts_d       = pts_q;
    smp_cnt_d   = smp_cnt_q;
    push_pend_d = push_pend_q;
    acc_d       = acc_q;
    err_set_s   = 1'b0;

    if (abort_s) begin
      state_d     = ST_IDLE;
      pts_d       = '0;
      smp_cnt_d   = '0;
      push_pend_d = 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            state_d     = ST_CAPTURE;
            pts_d       = '0;
            smp_cnt_d   = '0;
            push_pend_d = 1'b0;
            for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
          end else if (pop_s && (state_q == ST_DONE) && (fifo_count_s == PW'(1))) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        ST_CAPTURE: begin
          err_set_s   = start_s;
          push_pend_d = 1'b0;
          // A sample landing on the push cycle seeds the next group's sum
          for (int c = 0; c < CHANNELS; c++) begin
            acc_d[c] = push_s ? '0 : acc_q[c];
          end
          if (bus.adc_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
              acc_d[c] = acc_d[c] + ACC_W'(bus.adc_data[c*ADC_WIDTH +: ADC_WIDTH]);
            end
            if (smp_next_s == group_len_s) begin
              smp_cnt_d   = '0;
              push_pend_d = 1'b1;
            end else begin
              smp_cnt_d = smp_next_s;
            end
          end else begin
            smp_cnt_d = smp_cnt_q;
          end
          if (push_s) begin
            pts_d = pts_next_s;
            if (pts_next_s == npoints_q) begin
              state_d     = ST_DONE;
              smp_cnt_d   = '0;
              push_pend_d = 1'b0;
              for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
            end else begin
              state_d = ST_CAPTURE;
            end
          end else begin
            pts_d = pts_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (wr_s && (bus.cmd_addr == ADDR_NPOINTS)) begin
      if (in_capture_s) begin
        err_set_s = 1'b1;
      end else if (bus.cmd_wdata == 24'd0) begin
        npoints_d = PW'(1);
      end else if (bus.cmd_wdata > 24'(DEPTH)) begin
        npoints_d = PW'(DEPTH);
      end else begin
        npoints_d = bus.cmd_wdata[PW-1:0];
      end
    end else if (wr_s && (bus.cmd_addr == ADDR_AVG)) begin
      if (in_capture_s) begin
        err_set_s = 1'b1;
      end else if (bus.cmd_wdata > 24'(AVG_LOG2_MAX)) begin
        avg_d = AVW'(AVG_LOG2_MAX);
      end else begin
        avg_d = bus.cmd_wdata[AVW-1:0];
      end
    end else begin
      npoints_d = npoints_d;
    end

    err_d = (err_q & ~clr_err_s) | err_set_s | (rd_req_s & fifo_empty_s);

    status_s = '0;
    status_s[STAT_STATE_LSB +: 2]            = state_q;
    status_s[STAT_ERR_BIT]                   = err_q;
    status_s[STAT_EMPTY_BIT]                 = fifo_empty_s;
    status_s[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count_s);

    if (rd_s) begin
      case (bus.cmd_addr)
        ADDR_ID:      cmd_rdata_d = DEVICE_ID;
        ADDR_NPOINTS: cmd_rdata_d = 24'(npoints_q);
        ADDR_AVG:     cmd_rdata_d = 24'(avg_q);
        ADDR_STATUS:  cmd_rdata_d = status_s;
        default:      cmd_rdata_d = 24'd0;
      endcase
    end else begin
      cmd_rdata_d = cmd_rdata_q;
    end

    busy_d     = (state_d == ST_CAPTURE);
    done_d     = (state_d == ST_DONE);
    rd_valid_d = pop_s;
  end

  // All controller state and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      npoints_q   <= PW'(DEPTH);
      avg_q       <= '0;
      pts_q       <= '0;
      smp_cnt_q   <= '0;
      push_pend_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      cmd_rdata_q <= 24'd0;
    end else begin
      state_q     <= state_d;
      npoints_q   <= npoints_d;
      avg_q       <= avg_d;
      pts_q       <= pts_d;
      smp_cnt_q   <= smp_cnt_d;
      push_pend_q <= push_pend_d;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      cmd_rdata_q <= cmd_rdata_d;
    end
  end

  assign bus.cmd_rdata = cmd_rdata_q;
  assign bus.rd_data   = fifo_dout_s;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.meas_done = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_meas_capture_ctrl.sv
// Directed self-checking bench for meas_capture_ctrl with hand-computed
// register values, averaged words and a full-depth capture/drain.
module tb_meas_capture_ctrl;

  logic sys_clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  meas_capture_ctrl_if #(.ADC_WIDTH(12), .CHANNELS(2)) bus ();

  meas_capture_ctrl #(
    .ADC_WIDTH    (12),
    .CHANNELS     (2),
    .DEPTH        (4096),
    .AVG_LOG2_MAX (4),
    .DEVICE_ID    (24'hF0CCAB)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cmd_write(input logic [6:0] addr, input logic [23:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    cyc();
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
  endtask

  task automatic cmd_read(input logic [6:0] addr, output logic [23:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = addr;
    cyc();
    data          = bus.cmd_rdata;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic sample(input logic [11:0] ch0, input logic [11:0] ch1);
    bus.adc_valid = 1'b1;
    bus.adc_data  = {ch1, ch0};
    cyc();
    bus.adc_valid = 1'b0;
  endtask

  task automatic pop(output logic [23:0] data, output logic vld);
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
    data      = bus.rd_data;
    vld       = bus.rd_valid;
  endtask

  initial begin
    logic [23:0] rd;
    logic        v;
    logic [11:0] k12;
    logic [23:0] exp_words [4];

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 7'h00;
    bus.cmd_wdata = 24'h000000;
    bus.adc_valid = 1'b0;
    bus.adc_data  = 24'h000000;
    bus.rd_en     = 1'b0;
    repeat (3) cyc();
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.meas_done}, 32'd0);
    check_eq("rst_err", {31'd0, bus.err}, 32'd0);
    check_eq("rst_rdata", {8'd0, bus.cmd_rdata}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: ID and idle STATUS
    cmd_read(7'h00, rd);
    check_eq("id", {8'd0, rd}, 32'h00F0CCAB);
    cmd_read(7'h04, rd);
    check_eq("status_idle", {8'd0, rd}, 32'h00000008);
    cmd_read(7'h02, rd);
    check_eq("npoints_rst", {8'd0, rd}, 32'd4096);

    // 2: four plain points
    cmd_write(7'h02, 24'd4);
    cmd_write(7'h03, 24'd0);
    cmd_write(7'h01, 24'h000001);
    check_eq("t2_busy", {31'd0, bus.busy}, 32'd1);
    cmd_read(7'h04, rd);
    check_eq("t2_status_cap", {8'd0, rd}, 32'h00000009);
    for (int k = 1; k <= 4; k++) begin
      k12 = 12'(k);
      sample(k12, k12 + 12'h100);
    end
    check_eq("t2_done_latency", {31'd0, bus.meas_done}, 32'd0);
    cyc();
    check_eq("t2_done", {31'd0, bus.meas_done}, 32'd1);
    check_eq("t2_busy_off", {31'd0, bus.busy}, 32'd0);
    cmd_read(7'h04, rd);
    check_eq("t2_status_done", {8'd0, rd}, 32'h00000402);
    exp_words[0] = 24'h101001;
    exp_words[1] = 24'h102002;
    exp_words[2] = 24'h103003;
    exp_words[3] = 24'h104004;
    for (int i = 0; i < 4; i++) begin
      pop(rd, v);
      check_eq($sformatf("t2_rdvalid%0d", i), {31'd0, v}, 32'd1);
      check_eq($sformatf("t2_rddata%0d", i), {8'd0, rd}, {8'd0, exp_words[i]});
    end
    check_eq("t2_done_cleared", {31'd0, bus.meas_done}, 32'd0);
    cmd_read(7'h04, rd);
    check_eq("t2_status_idle", {8'd0, rd}, 32'h00000008);
    check_eq("t2_rddata_hold", {8'd0, bus.rd_data}, 32'h00104004);

    // 3: averaging over 4 samples, back-to-back groups
    cmd_write(7'h02, 24'd2);
    cmd_write(7'h03, 24'd2);
    cmd_write(7'h01, 24'h000001);
    sample(12'd1, 12'h010);
    sample(12'd2, 12'h020);
    sample(12'd3, 12'h030);
    sample(12'd5, 12'h040);
    for (int i = 0; i < 4; i++) sample(12'hFFF, 12'hFFF);
    cyc();
    check_eq("t3_done", {31'd0, bus.meas_done}, 32'd1);
    pop(rd, v);
    check_eq("t3_word0", {8'd0, rd}, 32'h00028002);
    pop(rd, v);
    check_eq("t3_word1", {8'd0, rd}, 32'h00FFFFFF);
    check_eq("t3_valid1", {31'd0, v}, 32'd1);

    // 4: ABORT coincident with a sample
    cmd_write(7'h02, 24'd8);
    cmd_write(7'h03, 24'd0);
    cmd_write(7'h01, 24'h000001);
    for (int i = 0; i < 3; i++) sample(12'(i + 7), 12'h055);
    bus.adc_valid = 1'b1;
    bus.adc_data  = 24'h055009;
    cmd_write(7'h01, 24'h000002);
    bus.adc_valid = 1'b0;
    check_eq("t4_busy", {31'd0, bus.busy}, 32'd0);
    cmd_read(7'h04, rd);
    check_eq("t4_status", {8'd0, rd}, 32'h00000008);
    pop(rd, v);
    check_eq("t4_rdvalid", {31'd0, v}, 32'd0);
    check_eq("t4_err", {31'd0, bus.err}, 32'd1);
    cmd_write(7'h01, 24'h000004);
    check_eq("t4_clr_err", {31'd0, bus.err}, 32'd0);

    // 5: clamping and config lockout during capture
    cmd_write(7'h02, 24'd0);
    cmd_read(7'h02, rd);
    check_eq("t5_np_zero", {8'd0, rd}, 32'd1);
    cmd_write(7'h02, 24'd5000);
    cmd_read(7'h02, rd);
    check_eq("t5_np_big", {8'd0, rd}, 32'd4096);
    cmd_write(7'h03, 24'd9);
    cmd_read(7'h03, rd);
    check_eq("t5_avg_big", {8'd0, rd}, 32'd4);
    cmd_write(7'h02, 24'd3);
    cmd_write(7'h03, 24'd0);
    cmd_write(7'h01, 24'h000001);
    cmd_write(7'h02, 24'd7);
    cmd_read(7'h02, rd);
    check_eq("t5_np_locked", {8'd0, rd}, 32'd3);
    check_eq("t5_err", {31'd0, bus.err}, 32'd1);
    cmd_read(7'h04, rd);
    check_eq("t5_status_cap_err", {8'd0, rd}, 32'h0000000D);
    cmd_read(7'h55, rd);
    check_eq("t5_unmapped", {8'd0, rd}, 32'd0);
    cmd_write(7'h01, 24'h000002);
    cmd_write(7'h01, 24'h000004);
    check_eq("t5_clr_err", {31'd0, bus.err}, 32'd0);

    // 6: full-depth capture and drain across pointer wrap
    cmd_write(7'h02, 24'd4096);
    cmd_write(7'h01, 24'h000001);
    for (int i = 0; i < 4096; i++) begin
      k12 = 12'(i);
      sample(k12, ~k12);
    end
    check_eq("t6_done_early", {31'd0, bus.meas_done}, 32'd0);
    cyc();
    check_eq("t6_done", {31'd0, bus.meas_done}, 32'd1);
    sample(12'h123, 12'h456);
    cmd_read(7'h04, rd);
    check_eq("t6_status_full", {8'd0, rd}, 32'h00100002);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      cyc();
      k12 = 12'(i);
      check_eq("t6_drain_valid", {31'd0, bus.rd_valid}, 32'd1);
      check_eq($sformatf("t6_drain_data%0d", i), {8'd0, bus.rd_data}, {8'd0, ~k12, k12});
    end
    bus.rd_en = 1'b0;
    check_eq("t6_idle", {31'd0, bus.meas_done}, 32'd0);
    cmd_read(7'h04, rd);
    check_eq("t6_status_empty", {8'd0, rd}, 32'h00000008);
    pop(rd, v);
    check_eq("t6_empty_rdvalid", {31'd0, v}, 32'd0);
    check_eq("t6_empty_err", {31'd0, bus.err}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
